id_operand_stage: RTL
=====================

Name: id_operand_stage

Overview:
- Decode-side pipeline stage that sits directly downstream of the bypassing unit and consumes its per-stage write-back information (EXE/MEM/WB address, data, data-valid, write-enable).
- Holds the ID pipeline register with valid/allowin handshakes, reads source operands from the register file and overrides them with forwarded data.
- Stalls on unresolved hazards, for example a load still in EXE.
- Keeps a saturating stall-cycle counter for performance analysis.

Parameters:
- DATA_WIDTH, 32, width of operands and forwarded data
- PC_WIDTH, 32, width of the program counter
- STALL_CNT_WIDTH, 16, width of the saturating stall counter

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- fs_to_ds_valid  in  1  upstream (IF) holds a valid instruction
- fs_pc  in  PC_WIDTH  PC of the incoming instruction
- fs_src1_addr / fs_src2_addr  in  5 each  source register numbers
- fs_src1_used / fs_src2_used  in  1 each  source actually read by the instruction
- fs_dest_addr  in  5  destination register number, passed through
- ds_allowin  out  1  ID can accept an instruction this cycle
- flush  in  1  kill the ID content (taken branch / exception)
- rf_raddr1 / rf_raddr2  out  5 each  register-file read addresses (from the ID register)
- rf_rdata1 / rf_rdata2  in  DATA_WIDTH each  combinational register-file read data
- exe_waddr, mem_waddr, wb_waddr  in  5 each  bypass destination address per stage
- exe_wdata, mem_wdata, wb_wdata  in  DATA_WIDTH each  bypass data per stage
- exe_dvalid, mem_dvalid, wb_dvalid  in  1 each  bypass data is final in that stage
- exe_wen, mem_wen, wb_wen  in  1 each  stage will write the register file
- es_allowin  in  1  downstream EXE accepts
- ds_to_es_valid  out  1  ID presents a valid, hazard-free instruction
- ds_pc  out  PC_WIDTH  registered PC
- ds_src1_data / ds_src2_data  out  DATA_WIDTH each  final operands
- ds_dest_addr  out  5  registered destination
- stall_cnt  out  STALL_CNT_WIDTH  stall cycles since reset

Behaviour:
- Reset (asynchronous):
  - ds_valid=0; PC, source/destination addresses and used flags = 0; stall_cnt=0.
  - Outputs therefore reset to: ds_to_es_valid=0, ds_pc=0, ds_dest_addr=0, both operands=0, ds_allowin=1.
- Handshake:
  - ds_ready_go = !hazard.
  - ds_allowin = !ds_valid | (ds_ready_go & es_allowin).
  - ds_to_es_valid = ds_valid & ds_ready_go.
- ID register update:
  - On fs_to_ds_valid & ds_allowin: capture PC, addresses and used flags; set ds_valid=1.
  - Else, if ds_to_es_valid & es_allowin: ds_valid=0.
  - flush has highest priority: ds_valid=0 the next cycle and no capture that cycle, even if fs_to_ds_valid=1.
- Operand select, combinational, per source from the registered address:
  - Address 0 -> operand 0; r0 is never forwarded or stalled on.
  - Otherwise priority is EXE > MEM > WB > rf_rdata.
  - A stage matches when its wen=1 and its waddr equals the source address.
  - Only the highest-priority matching stage is considered.
- Hazard:
  - Raised for a source when used=1 and its highest-priority matching stage has dvalid=0 (for example a load in EXE or MEM).
  - hazard = OR over both sources, qualified with ds_valid.
  - Unused sources never cause a hazard.
- Operand outputs are recomputed every cycle, so a stall resolves in the cycle the producing stage raises dvalid or moves on.
- No extra latency: an instruction can leave ID the cycle after it is captured.
- Back-pressure: with es_allowin=0 the ID register holds all fields stable and ds_allowin=0 while ds_valid=1.
- stall_cnt:
  - Increments by 1 on every cycle with ds_valid & hazard.
  - Saturates at all-ones; never wraps.
  - Cleared only by reset.
  - Cycles blocked only by es_allowin=0 are not counted.
- Reset asserted mid-stall immediately clears ds_valid and the counter; no instruction is emitted.

Test Plan:
- Reset, then one instruction with src1=r5, rf_rdata1=0x11, no bypass matches -> next cycle ds_to_es_valid=1, ds_src1_data=0x11, stall_cnt=0.
- src1=r3, exe/mem/wb all write r3 with data 0xA, 0xB, 0xC, all dvalid=1 -> ds_src1_data=0xA; drop exe_wen -> 0xB; also drop mem_wen -> 0xC.
- Load-use: src2=r7 used, exe_waddr=7, exe_wen=1, exe_dvalid=0 for 2 cycles, then the value moves to MEM with mem_dvalid=1 and data 0x55 -> ds_to_es_valid=0 for 2 cycles, then 1 with ds_src2_data=0x55; stall_cnt=2, ds_allowin=0 during the stall.
- src1=r0 with exe_waddr=0, exe_wen=1, exe_dvalid=0 -> no stall, ds_src1_data=0; same hazard with src1_used=0 on r4 -> no stall.
- es_allowin=0 for 3 cycles with a valid, hazard-free instruction -> fields stable, ds_allowin=0, stall_cnt unchanged; flush in the same cycle as fs_to_ds_valid=1 -> ds_valid=0 the next cycle.
- Force a permanent hazard with STALL_CNT_WIDTH=4 for 20 cycles -> stall_cnt saturates at 15; assert reset mid-stall -> stall_cnt=0 and ds_to_es_valid=0 immediately.

Source files
------------

// File: rtl/id_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_operand_stage
// Brief    : ID pipeline register with register-file read, EXE/MEM/WB operand
//            forwarding, hazard stall and saturating stall-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module id_operand_stage #(
    parameter int DATA_WIDTH      = 32,
    parameter int PC_WIDTH        = 32,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fs_to_ds_valid,
    input  logic [PC_WIDTH-1:0]        fs_pc,
    input  logic [4:0]                 fs_src1_addr,
    input  logic [4:0]                 fs_src2_addr,
    input  logic                       fs_src1_used,
    input  logic                       fs_src2_used,
    input  logic [4:0]                 fs_dest_addr,
    output logic                       ds_allowin,
    input  logic                       flush,
    output logic [4:0]                 rf_raddr1,
    output logic [4:0]                 rf_raddr2,
    input  logic [DATA_WIDTH-1:0]      rf_rdata1,
    input  logic [DATA_WIDTH-1:0]      rf_rdata2,
    input  logic [4:0]                 exe_waddr,
    input  logic [4:0]                 mem_waddr,
    input  logic [4:0]                 wb_waddr,
    input  logic [DATA_WIDTH-1:0]      exe_wdata,
    input  logic [DATA_WIDTH-1:0]      mem_wdata,
    input  logic [DATA_WIDTH-1:0]      wb_wdata,
    input  logic                       exe_dvalid,
    input  logic                       mem_dvalid,
    input  logic                       wb_dvalid,
    input  logic                       exe_wen,
    input  logic                       mem_wen,
    input  logic                       wb_wen,
    input  logic                       es_allowin,
    output logic                       ds_to_es_valid,
    output logic [PC_WIDTH-1:0]        ds_pc,
    output logic [DATA_WIDTH-1:0]      ds_src1_data,
    output logic [DATA_WIDTH-1:0]      ds_src2_data,
    output logic [4:0]                 ds_dest_addr,
    output logic [STALL_CNT_WIDTH-1:0] stall_cnt
);

    localparam logic [STALL_CNT_WIDTH-1:0] c_cnt_max = '1;
    localparam logic [STALL_CNT_WIDTH-1:0] c_cnt_one = {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                       r_ds_valid;
    logic [PC_WIDTH-1:0]        r_pc;
    logic [4:0]                 r_src1_addr;
    logic [4:0]                 r_src2_addr;
    logic                       r_src1_used;
    logic                       r_src2_used;
    logic [4:0]                 r_dest_addr;
    logic [STALL_CNT_WIDTH-1:0] r_stall_cnt;

    logic [4:0]            w_src_addr [2];
    logic                  w_src_used [2];
    logic [DATA_WIDTH-1:0] w_rf_data  [2];
    logic [DATA_WIDTH-1:0] w_src_data [2];
    logic                  w_src_haz  [2];
    logic                  w_hazard;
    logic                  w_ds_allowin;
    logic                  w_ds_to_es_valid;

    assign w_src_addr[0] = r_src1_addr;
    assign w_src_addr[1] = r_src2_addr;
    assign w_src_used[0] = r_src1_used;
    assign w_src_used[1] = r_src2_used;
    assign w_rf_data[0]  = rf_rdata1;
    assign w_rf_data[1]  = rf_rdata2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic w_nonzero;
            logic w_exe_hit;
            logic w_mem_hit;
            logic w_wb_hit;

            assign w_nonzero = (w_src_addr[gi] != 5'd0);
            assign w_exe_hit = exe_wen && (exe_waddr == w_src_addr[gi]);
            assign w_mem_hit = mem_wen && (mem_waddr == w_src_addr[gi]);
            assign w_wb_hit  = wb_wen  && (wb_waddr  == w_src_addr[gi]);

            // Only the youngest matching stage counts; an older final value
            // must not hide a younger producer that is still pending.
            assign w_src_data[gi] = !w_nonzero ? '0        :
                                    w_exe_hit  ? exe_wdata :
                                    w_mem_hit  ? mem_wdata :
                                    w_wb_hit   ? wb_wdata  : w_rf_data[gi];

            assign w_src_haz[gi] = w_src_used[gi] && w_nonzero &&
                                   (w_exe_hit ? !exe_dvalid :
                                    w_mem_hit ? !mem_dvalid :
                                    w_wb_hit  ? !wb_dvalid  : 1'b0);
        end
    endgenerate

    assign w_hazard         = r_ds_valid && (w_src_haz[0] || w_src_haz[1]);
    assign w_ds_to_es_valid = r_ds_valid && !w_hazard;
    assign w_ds_allowin     = !r_ds_valid || (!w_hazard && es_allowin);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ds_valid  <= 1'b0;
            r_pc        <= '0;
            r_src1_addr <= '0;
            r_src2_addr <= '0;
            r_src1_used <= 1'b0;
            r_src2_used <= 1'b0;
            r_dest_addr <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (flush) begin
                r_ds_valid <= 1'b0;
            end else if (fs_to_ds_valid && w_ds_allowin) begin
                r_ds_valid  <= 1'b1;
                r_pc        <= fs_pc;
                r_src1_addr <= fs_src1_addr;
                r_src2_addr <= fs_src2_addr;
                r_src1_used <= fs_src1_used;
                r_src2_used <= fs_src2_used;
                r_dest_addr <= fs_dest_addr;
            end else if (w_ds_to_es_valid && es_allowin) begin
                r_ds_valid <= 1'b0;
            end

            if (w_hazard && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
            end
        end
    end

    assign ds_allowin     = w_ds_allowin;
    assign ds_to_es_valid = w_ds_to_es_valid;
    assign rf_raddr1      = r_src1_addr;
    assign rf_raddr2      = r_src2_addr;
    assign ds_pc          = r_pc;
    assign ds_src1_data   = w_src_data[0];
    assign ds_src2_data   = w_src_data[1];
    assign ds_dest_addr   = r_dest_addr;
    assign stall_cnt      = r_stall_cnt;

endmodule
`default_nettype wire
